// File: rtl/phase_meas_ctrl_pkg.sv
// Shared definitions for the phase measurement controller and for other
// measurement blocks that reuse the same sequencing states and defaults.
//   meas_state_e : controller state encoding
//   BCD_DIGITS   : packed BCD digits on the readout bus (MSD in the top nibble)
//   DEF_*        : default counter width, averaging depth and timeout
package phase_meas_ctrl_pkg;

   localparam int BCD_DIGITS   = 8;
   localparam int BCD_W        = 4 * BCD_DIGITS;

   localparam int DEF_CNT_W    = 27;
   localparam int DEF_AVG_LOG2 = 2;
   localparam int DEF_TIMEOUT  = 100_000_000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_COUNT   = 3'd2,
      ST_ACCUM   = 3'd3,
      ST_CONVERT = 3'd4,
      ST_DONE    = 3'd5
   } meas_state_e;

endpackage

// File: rtl/phase_meas_ctrl_bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (double dabble, one shift per clock).
// Ports:
//   clk_100M : clock
//   rst      : asynchronous active-low reset
//   go_i     : load request, ignored while a conversion is running
//   bin_i    : binary value sampled with go_i
//   bcd_o    : packed BCD result, MSD in the top nibble; holds after done_o
//   done_o   : one-cycle pulse CNT_W+1 cycles after the go_i cycle
module bin2bcd_seq
   import phase_meas_ctrl_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk_100M,
   input  logic             rst,
   input  logic             go_i,
   input  logic [CNT_W-1:0] bin_i,
   output logic [BCD_W-1:0] bcd_o,
   output logic             done_o
);

   localparam int CW = $clog2(CNT_W + 1);

   logic [CNT_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             active_q, active_d;
   logic             done_q, done_d;

   // add-3 on every digit >= 5 before the shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] > 4'd4) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      done_d   = 1'b0;
      if (active_q) begin
         bcd_d = {bcd_adj[BCD_W-2:0], bin_q[CNT_W-1]};
         bin_d = {bin_q[CNT_W-2:0], 1'b0};
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end else if (go_i) begin
         bin_d    = bin_i;
         bcd_d    = '0;
         cnt_d    = CW'(CNT_W);
         active_d = 1'b1;
      end
   end

   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = done_q;

endmodule

// File: rtl/phase_meas_ctrl.sv
// Inter-channel time-difference sequencer: measures the cycle distance from a
// sign0 rising edge to the following sign1 rising edge, averages 2^AVG_LOG2
// samples and publishes the mean in binary and packed BCD.
// Ports:
//   clk_100M : 100 MHz clock
//   rst      : asynchronous active-low reset
//   start    : burst request, honoured only in IDLE
//   sign0/1  : asynchronous comparator outputs (start / stop channel)
//   busy     : high outside IDLE
//   timeout  : sticky abort flag, cleared by the next accepted start
//   bin_out  : averaged difference in clock cycles
//   bcd_out  : bin_out as packed BCD
//   valid    : one-cycle strobe when bin_out/bcd_out update
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// ARM      | waiting for a sign0 edge (timer running)
// COUNT    | counting cycles until a sign1 edge (timer == counter)
// ACCUM    | add sample to sum, next sample or finish the burst
// CONVERT  | converter running on the mean
// DONE     | register results and strobe valid
module phase_meas_ctrl
   import phase_meas_ctrl_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int AVG_LOG2 = DEF_AVG_LOG2,
   parameter int TIMEOUT  = DEF_TIMEOUT
) (
   input  logic             clk_100M,
   input  logic             rst,
   input  logic             start,
   input  logic             sign0,
   input  logic             sign1,
   output logic             busy,
   output logic             timeout,
   output logic [CNT_W-1:0] bin_out,
   output logic [BCD_W-1:0] bcd_out,
   output logic             valid
);

   localparam int SUM_W = CNT_W + AVG_LOG2;
   localparam int IDX_W = AVG_LOG2 + 1;
   localparam int NSAMP = 1 << AVG_LOG2;
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSAMP - 1);

   meas_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] sample_q, sample_d;
   logic [SUM_W-1:0] sum_q, sum_d, sum_acc;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] mean_q, mean_d;
   logic             timeout_q, timeout_d;
   logic             go_q, go_d;
   logic [CNT_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic             valid_q, valid_d;

   logic s0_meta_q, s0_sync_q, s0_hist_q;
   logic s1_meta_q, s1_sync_q, s1_hist_q;
   logic rise0, rise1;

   logic [BCD_W-1:0] conv_bcd;
   logic             conv_done;

   // All conditioning flops reset high so a channel already high at reset
   // release never looks like a fresh rising edge.
   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         s0_meta_q <= 1'b1;
         s0_sync_q <= 1'b1;
         s0_hist_q <= 1'b1;
         s1_meta_q <= 1'b1;
         s1_sync_q <= 1'b1;
         s1_hist_q <= 1'b1;
      end else begin
         s0_meta_q <= sign0;
         s0_sync_q <= s0_meta_q;
         s0_hist_q <= s0_sync_q;
         s1_meta_q <= sign1;
         s1_sync_q <= s1_meta_q;
         s1_hist_q <= s1_sync_q;
      end
   end

   assign rise0   = s0_sync_q & ~s0_hist_q;
   assign rise1   = s1_sync_q & ~s1_hist_q;
   assign sum_acc = sum_q + SUM_W'(sample_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sample_d  = sample_q;
      sum_d     = sum_q;
      idx_d     = idx_q;
      mean_d    = mean_q;
      timeout_d = timeout_q;
      go_d      = 1'b0;
      bin_d     = bin_q;
      bcd_d     = bcd_q;
      valid_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_ARM;
               timeout_d = 1'b0;
               sum_d     = '0;
               idx_d     = '0;
               cnt_d     = '0;
            end
         end
         ST_ARM: begin
            // a sign1 edge in this state is deliberately not looked at
            if (rise0) begin
               state_d = ST_COUNT;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_COUNT: begin
            // the awaited edge wins over a timeout in the same cycle
            if (rise1) begin
               sample_d = cnt_q + CNT_W'(1);
               state_d  = ST_ACCUM;
            end else if (cnt_q == TO_LAST) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_ACCUM: begin
            sum_d = sum_acc;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = ST_CONVERT;
               mean_d  = CNT_W'(sum_acc >> AVG_LOG2);
               go_d    = 1'b1;
            end else begin
               state_d = ST_ARM;
               cnt_d   = '0;
            end
         end
         ST_CONVERT: begin
            if (conv_done) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            bin_d   = mean_q;
            bcd_d   = conv_bcd;
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_100M or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         sample_q  <= '0;
         sum_q     <= '0;
         idx_q     <= '0;
         mean_q    <= '0;
         timeout_q <= 1'b0;
         go_q      <= 1'b0;
         bin_q     <= '0;
         bcd_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sample_q  <= sample_d;
         sum_q     <= sum_d;
         idx_q     <= idx_d;
         mean_q    <= mean_d;
         timeout_q <= timeout_d;
         go_q      <= go_d;
         bin_q     <= bin_d;
         bcd_q     <= bcd_d;
         valid_q   <= valid_d;
      end
   end

   bin2bcd_seq #(
      .CNT_W (CNT_W)
   ) u_bin2bcd (
      .clk_100M (clk_100M),
      .rst      (rst),
      .go_i     (go_q),
      .bin_i    (mean_q),
      .bcd_o    (conv_bcd),
      .done_o   (conv_done)
   );

   assign busy    = (state_q != ST_IDLE);
   assign timeout = timeout_q;
   assign bin_out = bin_q;
   assign bcd_out = bcd_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_phase_meas_ctrl.sv
module tb_phase_meas_ctrl;

   localparam int CNT_W    = 27;
   localparam int AVG_LOG2 = 2;
   localparam int TO_BIG   = 5000;
   localparam int TO_SMALL = 1000;
   // input drive -> valid: 3 cycles of synchroniser/edge detect, then CNT_W+4
   localparam int LAT      = CNT_W + 4 + 3;

   logic clk_100M = 1'b0;
   logic rst, start, sign0, sign1;

   logic             busy, timeout, valid;
   logic [CNT_W-1:0] bin_out;
   logic [31:0]      bcd_out;

   logic             busy_s, timeout_s, valid_s;
   logic [CNT_W-1:0] bin_s;
   logic [31:0]      bcd_s;

   logic             cgo, cdone;
   logic [CNT_W-1:0] cbin;
   logic [31:0]      cbcd;

   int vectors     = 0;
   int miscompares = 0;
   int valid_cnt   = 0;
   int valid_s_cnt = 0;
   int samp [4];

   phase_meas_ctrl #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TO_BIG)) u_dut (
      .clk_100M (clk_100M), .rst (rst), .start (start), .sign0 (sign0), .sign1 (sign1),
      .busy (busy), .timeout (timeout), .bin_out (bin_out), .bcd_out (bcd_out), .valid (valid)
   );

   phase_meas_ctrl #(.CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TO_SMALL)) u_dut_s (
      .clk_100M (clk_100M), .rst (rst), .start (start), .sign0 (sign0), .sign1 (sign1),
      .busy (busy_s), .timeout (timeout_s), .bin_out (bin_s), .bcd_out (bcd_s), .valid (valid_s)
   );

   bin2bcd_seq #(.CNT_W(CNT_W)) u_conv (
      .clk_100M (clk_100M), .rst (rst), .go_i (cgo), .bin_i (cbin), .bcd_o (cbcd), .done_o (cdone)
   );

   initial forever #5 clk_100M = ~clk_100M;

   always @(posedge clk_100M) begin
      if (valid === 1'b1)   valid_cnt   <= valid_cnt + 1;
      if (valid_s === 1'b1) valid_s_cnt <= valid_s_cnt + 1;
   end

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk_100M);
      #1;
   endtask

   task automatic send_sample(input int d);
      sign0 = 1'b1;
      step(d);
      sign1 = 1'b1;
      step(4);
      sign0 = 1'b0;
      sign1 = 1'b0;
      step(6);
   endtask

   // Runs one 4-sample burst from samp[]; the last sample measures latency.
   task automatic run_burst(input bit same_cycle, input string name);
      int          exp_mean;
      logic [31:0] exp_bcd;
      int          n_lat;
      int          v0;
      exp_mean = (samp[0] + samp[1] + samp[2] + samp[3]) / 4;
      exp_bcd  = to_bcd(exp_mean);
      v0       = valid_cnt;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      for (int i = 0; i < 3; i++) begin
         if (i == 0 && same_cycle) begin
            sign0 = 1'b1;
            sign1 = 1'b1;
            step(3);
            sign1 = 1'b0;
            step(7);
            start = 1'b1;
            step(1);
            start = 1'b0;
            step(samp[0] - 11);
            sign1 = 1'b1;
            step(4);
            sign0 = 1'b0;
            sign1 = 1'b0;
            step(6);
         end else begin
            send_sample(samp[i]);
         end
      end
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s busy_mid: got %b want 1", name, busy);
      end
      sign0 = 1'b1;
      step(samp[3]);
      sign1 = 1'b1;
      n_lat = 0;
      for (int n = 1; n <= 80; n++) begin
         step(1);
         if (valid === 1'b1) begin
            n_lat = n;
            break;
         end
      end
      vectors++;
      if (n_lat != LAT) begin
         miscompares++;
         $display("FAIL %s latency: got %0d want %0d", name, n_lat, LAT);
      end
      vectors++;
      if (bin_out !== CNT_W'(exp_mean)) begin
         miscompares++;
         $display("FAIL %s bin_out: got %0d want %0d", name, bin_out, exp_mean);
      end
      vectors++;
      if (bcd_out !== exp_bcd) begin
         miscompares++;
         $display("FAIL %s bcd_out: got %h want %h", name, bcd_out, exp_bcd);
      end
      vectors++;
      if (busy !== 1'b0 || timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL %s busy/timeout: got %b/%b want 0/0", name, busy, timeout);
      end
      step(1);
      vectors++;
      if (valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s valid_width: got %b want 0", name, valid);
      end
      sign0 = 1'b0;
      sign1 = 1'b0;
      step(4);
      vectors++;
      if (valid_cnt - v0 != 1) begin
         miscompares++;
         $display("FAIL %s valid_count: got %0d want 1", name, valid_cnt - v0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; sign0 = 1'b0; sign1 = 1'b0; cgo = 1'b0; cbin = '0;
      step(3);
      vectors++;
      if (busy !== 1'b0 || timeout !== 1'b0 || valid !== 1'b0 || bin_out !== '0 || bcd_out !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got busy=%b to=%b valid=%b bin=%0d bcd=%h want all 0",
                  busy, timeout, valid, bin_out, bcd_out);
      end
      rst = 1'b1;
      step(5);
      vectors++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: got busy=%b valid=%b want 0/0", busy, valid);
      end
   endtask

   task automatic conv_case(input int v, input bit inject);
      int n_done;
      int pulses;
      logic [31:0] exp_bcd;
      exp_bcd = to_bcd(v);
      n_done  = 0;
      pulses  = 0;
      cbin = CNT_W'(v);
      cgo  = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         step(1);
         if (n == 1) cgo = 1'b0;
         if (inject && n == 10) begin
            cgo  = 1'b1;
            cbin = CNT_W'(12345);
         end
         if (n == 11) cgo = 1'b0;
         if (cdone === 1'b1) begin
            pulses++;
            if (n_done == 0) n_done = n;
         end
      end
      vectors++;
      if (n_done != CNT_W + 1 || pulses != 1) begin
         miscompares++;
         $display("FAIL conv_done(%0d): got at %0d x%0d want at %0d x1", v, n_done, pulses, CNT_W + 1);
      end
      vectors++;
      if (cbcd !== exp_bcd) begin
         miscompares++;
         $display("FAIL conv_bcd(%0d): got %h want %h", v, cbcd, exp_bcd);
      end
   endtask

   task automatic test_bin2bcd();
      conv_case(99999999, 1'b1);
      conv_case(0, 1'b0);
      for (int i = 0; i < 3; i++) conv_case(int'($urandom_range(0, 99999999)), 1'b0);
   endtask

   task automatic test_fixed_1234();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 4; i++) samp[i] = 1234;
         run_burst(1'b0, "fixed1234");
      end
   endtask

   task automatic test_ramp();
      for (int i = 0; i < 4; i++) samp[i] = 100 + i;
      run_burst(1'b0, "ramp");
      vectors++;
      if (bin_s !== CNT_W'(101) || bcd_s !== 32'h0000_0101) begin
         miscompares++;
         $display("FAIL ramp_small: got %0d/%h want 101/00000101", bin_s, bcd_s);
      end
   endtask

   task automatic test_min();
      samp[0] = 1; samp[1] = 1; samp[2] = 1; samp[3] = 2;
      run_burst(1'b0, "min");
   endtask

   task automatic test_same_cycle();
      samp[0] = 50;
      for (int i = 1; i < 4; i++) samp[i] = int'($urandom_range(1, 300));
      run_burst(1'b1, "same_cycle");
   endtask

   task automatic test_random();
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 4; i++) samp[i] = int'($urandom_range(1, 600));
         run_burst(1'b0, "random");
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      send_sample(20);
      send_sample(20);
      sign0 = 1'b1;
      step(6);
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (busy !== 1'b0 || timeout !== 1'b0 || valid !== 1'b0 || bin_out !== '0 || bcd_out !== '0) begin
         miscompares++;
         $display("FAIL reset_mid: got busy=%b to=%b valid=%b bin=%0d bcd=%h want all 0",
                  busy, timeout, valid, bin_out, bcd_out);
      end
      sign0 = 1'b0;
      step(2);
      rst = 1'b1;
      step(3);
      for (int i = 0; i < 4; i++) samp[i] = 20;
      run_burst(1'b0, "after_reset");
   endtask

   task automatic test_timeout();
      logic [CNT_W-1:0] pre_bin;
      logic [31:0]      pre_bcd;
      int               v0;
      pre_bin = bin_s;
      pre_bcd = bcd_s;
      v0      = valid_s_cnt;
      // ARM never sees sign0
      start = 1'b1;
      for (int n = 1; n <= TO_SMALL + 1; n++) begin
         step(1);
         if (n == 1) start = 1'b0;
         if (n == TO_SMALL) begin
            vectors++;
            if (busy_s !== 1'b1) begin
               miscompares++;
               $display("FAIL arm_timeout_early: got busy=%b want 1", busy_s);
            end
         end
      end
      vectors++;
      if (busy_s !== 1'b0 || timeout_s !== 1'b1) begin
         miscompares++;
         $display("FAIL arm_timeout: got busy=%b to=%b want 0/1", busy_s, timeout_s);
      end
      // COUNT never sees sign1; the start also clears the flag
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      vectors++;
      if (timeout_s !== 1'b0 || busy_s !== 1'b1) begin
         miscompares++;
         $display("FAIL start_clears_timeout: got to=%b busy=%b want 0/1", timeout_s, busy_s);
      end
      sign0 = 1'b1;
      for (int n = 1; n <= TO_SMALL + 3; n++) begin
         step(1);
         if (n == TO_SMALL + 2) begin
            vectors++;
            if (busy_s !== 1'b1) begin
               miscompares++;
               $display("FAIL count_timeout_early: got busy=%b want 1", busy_s);
            end
         end
      end
      vectors++;
      if (busy_s !== 1'b0 || timeout_s !== 1'b1) begin
         miscompares++;
         $display("FAIL count_timeout: got busy=%b to=%b want 0/1", busy_s, timeout_s);
      end
      vectors++;
      if (bin_s !== pre_bin || bcd_s !== pre_bcd || valid_s_cnt != v0) begin
         miscompares++;
         $display("FAIL timeout_hold: got %0d/%h valids=%0d want %0d/%h valids=0",
                  bin_s, bcd_s, valid_s_cnt - v0, pre_bin, pre_bcd);
      end
      sign0 = 1'b0;
      step(3);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(2);
      vectors++;
      if (timeout_s !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_clear: got %b want 0", timeout_s);
      end
   endtask

   initial begin
      test_reset();
      test_bin2bcd();
      test_fixed_1234();
      test_ramp();
      test_min();
      test_same_cycle();
      test_random();
      test_reset_mid();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
